// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: multi-cycle shift-and-add multiplier that borrows the shared ALU.
//
// Forms the low WIDTH bits of op_a*op_b by alternating ADD and SHIFT states.
// In ADD the ALU adds the multiplicand into the accumulator when the current
// multiplier bit is set. In SHIFT the ALU shifts the multiplicand left by one.
// The result is modulo 2**WIDTH, so it is correct for signed and unsigned operands.
//
// Optional feature: define MUL_SEQ_EARLY_EXIT_EN to finish as soon as the
// remaining multiplier bits are all zero. Without it, latency is fixed at 2*WIDTH+1.
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous active-high reset
//   start    request, sampled only in IDLE or DONE
//   op_a     multiplicand, captured when start is accepted
//   op_b     multiplier, captured when start is accepted
//   busy     high while in ADD/SHIFT; the datapath selects this block as ALU master
//   done     one-cycle pulse when product becomes valid
//   product  registered result, held until the next accepted start
//   alu_op   ALU opcode: ADD=4'b0010, SLL=4'b1100, idle=4'b0000
//   alu_in1  ALU operand 1
//   alu_in2  ALU operand 2
//   alu_out  combinational ALU result for the current operands
module alu_mul_sequencer #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic [3:0]       alu_op,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    input  logic [WIDTH-1:0] alu_out
);
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b1100;

    typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] product_q;
    logic             add_en;
    logic             shift_en;

    // The ALU is only used in ADD when the current multiplier bit is set;
    // otherwise it is left idle so other masters see zeros.
    assign add_en   = (state_q == ADD) && mplier_q[0];
    assign shift_en = (state_q == SHIFT);

    always_comb begin
        busy    = (state_q == ADD) || shift_en;
        done    = (state_q == DONE);
        product = product_q;
        alu_op  = add_en ? OP_ADD : shift_en ? OP_SLL : 4'b0000;
        alu_in1 = add_en ? acc_q : shift_en ? mcand_q : '0;
        alu_in2 = add_en ? mcand_q : shift_en ? WIDTH'(1) : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        acc_q    <= '0;
                        mcand_q  <= op_a;
                        mplier_q <= op_b;
                        cnt_q    <= '0;
                        state_q  <= ADD;
                    end else begin
                        state_q  <= IDLE;
                    end
                end
                ADD: begin
`ifdef MUL_SEQ_EARLY_EXIT_EN
                    // No set bits left: the accumulator already holds the product.
                    if (mplier_q == '0) begin
                        product_q <= acc_q;
                        state_q   <= DONE;
                    end else begin
                        if (mplier_q[0]) acc_q <= alu_out;
                        state_q <= SHIFT;
                    end
`else
                    if (mplier_q[0]) acc_q <= alu_out;
                    state_q <= SHIFT;
`endif
                end
                SHIFT: begin
                    mcand_q  <= alu_out;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    // The last ADD came before this SHIFT, so acc is final here.
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        product_q <= acc_q;
                        state_q   <= DONE;
                    end else begin
                        state_q   <= ADD;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mul_sequencer.sv
// tb_alu_mul_sequencer: directed checks of the multiplier sequencer against a latency/product model.
module tb_alu_mul_sequencer;
`ifdef MUL_SEQ_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif
    localparam int BOUND = 300;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [63:0] op_a = '0;
    logic [63:0] op_b = '0;
    logic        busy;
    logic        done;
    logic [63:0] product;
    logic [3:0]  alu_op;
    logic [63:0] alu_in1;
    logic [63:0] alu_in2;
    logic [63:0] alu_out;

    int errs = 0;
    int checks = 0;

    alu_mul_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
        .busy(busy), .done(done), .product(product), .alu_op(alu_op),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_out(alu_out)
    );

    always #5 clk = ~clk;

    // Shared processor ALU: only ADD and SLL matter here.
    assign alu_out = (alu_op == 4'b0010) ? alu_in1 + alu_in2 :
                     (alu_op == 4'b1100) ? alu_in1 << alu_in2[5:0] : 64'd0;

    task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Cycles from accepting start to the done cycle.
    function automatic int lat(input logic [63:0] b);
        int k;
        k = 0;
        for (int i = 0; i < 64; i++) if (b[i]) k = i + 1;
        if (!EE) return 129;
        return (k == 64) ? 129 : 2 * k + 2;
    endfunction

    // Model: a job occupies lat-1 busy cycles, then done with the full product.
    int          m_rem;
    logic        m_done;
    logic [63:0] m_prod;
    logic [63:0] m_pend;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_rem  <= 0;
            m_done <= 1'b0;
            m_prod <= '0;
            m_pend <= '0;
        end else if (m_rem == 0) begin
            m_done <= 1'b0;
            if (start) begin
                m_rem  <= lat(op_b) - 1;
                m_pend <= op_a * op_b;
            end
        end else begin
            m_rem <= m_rem - 1;
            if (m_rem == 1) begin
                m_done <= 1'b1;
                m_prod <= m_pend;
            end
        end
    end

    always @(negedge clk) begin
        chk(busy == (m_rem != 0), "busy", 64'(busy), 64'(m_rem != 0));
        chk(done == m_done, "done", 64'(done), 64'(m_done));
        chk(product == m_prod, "product", product, m_prod);
        if (!busy)
            chk(alu_op == 4'b0000 && alu_in1 == '0 && alu_in2 == '0, "alu_idle", {alu_op, alu_in1[59:0]}, 64'd0);
        else
            chk(alu_op == 4'b0000 || alu_op == 4'b0010 || alu_op == 4'b1100, "alu_op_legal", 64'(alu_op), 64'h2);
    end

    // Starts a job from the current negedge and waits for done; leaves the bench
    // in the done cycle so a following call exercises back-to-back starts.
    task automatic run(input logic [63:0] a, input logic [63:0] b, input logic [63:0] ep,
                       input int el, input string nm);
        int n;
        op_a = a;
        op_b = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (!done && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        chk(done && n == el, {nm, "_latency"}, 64'(n), 64'(el));
        chk(product == ep, {nm, "_product"}, product, ep);
    endtask

    initial begin
        int n;
        int gap;
        repeat (2) @(negedge clk);
        chk(!busy && !done && product == '0, "reset_flags", {busy, done, product[61:0]}, 64'd0);
        chk(alu_op == '0 && alu_in1 == '0 && alu_in2 == '0, "reset_alu", alu_in1 | alu_in2 | 64'(alu_op), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        run(64'd3, 64'd5, 64'd15, EE ? 8 : 129, "a3b5");
        start = 1'b0;
        @(negedge clk);
        chk(!done, "done_pulse", 64'(done), 64'd0);

        run(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, EE ? 6 : 129, "ones_x2");
        run(64'h8000_0000_0000_0000, 64'd2, 64'd0, EE ? 6 : 129, "msb_x2");
        run(64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 64'hFFFF_FFFF_FFFF_FFF1, EE ? 8 : 129, "neg3x5");
        run(64'd12345, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_3039, 129, "b_msb");
        run(64'd99, 64'd0, 64'd0, EE ? 2 : 129, "b_zero");
        start = 1'b0;
        repeat (3) @(negedge clk);

        // Start during busy must be ignored.
        gap = EE ? 4 : 10;
        op_a = 64'd7;
        op_b = 64'd6;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (n < gap) begin
            @(negedge clk);
            n++;
        end
        op_a = 64'd1;
        op_b = 64'd1;
        start = 1'b1;
        @(negedge clk);
        n++;
        start = 1'b0;
        while (!done && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        chk(done && n == (EE ? 8 : 129), "ignore_start_latency", 64'(n), EE ? 64'd8 : 64'd129);
        chk(product == 64'd42, "ignore_start_product", product, 64'd42);
        @(negedge clk);

        // Reset in the middle of an operation.
        op_a = 64'd3;
        op_b = 64'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (EE ? 3 : 39) @(negedge clk);
        reset = 1'b1;
        #1;
        chk(!busy && !done, "midreset_flags", {62'd0, busy, done}, 64'd0);
        chk(product == '0, "midreset_product", product, 64'd0);
        chk(alu_op == '0 && alu_in1 == '0 && alu_in2 == '0, "midreset_alu", alu_in1 | alu_in2 | 64'(alu_op), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run(64'd4, 64'd4, 64'd16, EE ? 8 : 129, "a4b4");
        start = 1'b0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
